// File: rtl/a2d_arb.sv
// Round-robin arbiter/sequencer sharing one A2D converter among three requesters.
// Returns each result tagged with its requester ID and flags converters that never finish.
module a2d_arb #(
    parameter int GAP_CYC = 32,
    parameter int TMO_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [8:0]  req_chnnl,
    output logic [2:0]  gnt,
    output logic        start_conv,
    output logic [2:0]  chnnl,
    input  logic        cnv_cmplt,
    input  logic [11:0] A2D_res,
    output logic [11:0] res,
    output logic [1:0]  res_id,
    output logic        res_vld,
    output logic        tmo_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [1:0]  ptr_r;
    logic [15:0] cnt_r;
    logic [2:0]  gnt_r, chnnl_r;
    logic        start_conv_r, res_vld_r, tmo_err_r, busy_r;
    logic [11:0] res_r;
    logic [1:0]  res_id_r;

    logic [2:0]  pick_s;
    logic        pick_vld_s;
    logic [1:0]  pick_id_s;
    logic [2:0]  pick_chnnl_s;
    logic [1:0]  ptr_nxt_s;
    logic        cmplt_ok_s, tmo_hit_s, gap_done_s;

    // Search ptr, ptr+1, ptr+2 (mod 3); returns {found, id}.
    function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
        logic [2:0] sel;
        logic [2:0] c;
        sel = 3'b000;
        for (int k = 2; k >= 0; k--) begin
            c = {1'b0, p} + 3'(k);
            if (c >= 3'd3) begin
                c = c - 3'd3;
            end
            if (r[c[1:0]]) begin
                sel = {1'b1, c[1:0]};
            end
        end
        return sel;
    endfunction

    // Arbitration decode and condition flags.
    always_comb begin
        pick_s     = rr_pick(req, ptr_r);
        pick_vld_s = pick_s[2];
        pick_id_s  = pick_s[1:0];
        case (pick_id_s)
            2'd0:    begin pick_chnnl_s = req_chnnl[2:0]; ptr_nxt_s = 2'd1; end
            2'd1:    begin pick_chnnl_s = req_chnnl[5:3]; ptr_nxt_s = 2'd2; end
            2'd2:    begin pick_chnnl_s = req_chnnl[8:6]; ptr_nxt_s = 2'd0; end
            default: begin pick_chnnl_s = req_chnnl[2:0]; ptr_nxt_s = 2'd0; end
        endcase
        // A completion seen alongside start_conv belongs to the previous conversion.
        cmplt_ok_s = cnv_cmplt && !start_conv_r;
        tmo_hit_s  = (cnt_r == 16'(TMO_CYC - 1));
        gap_done_s = (cnt_r == 16'(GAP_CYC));
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (pick_vld_s) state_s = CONV;
                else            state_s = IDLE;
            end
            CONV: begin
                if (cmplt_ok_s || tmo_hit_s) state_s = (GAP_CYC == 0) ? IDLE : GAP;
                else                         state_s = CONV;
            end
            GAP: begin
                if (gap_done_s) state_s = IDLE;
                else            state_s = GAP;
            end
            default: state_s = IDLE;
        endcase
    end

    // State, counter, pointer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            ptr_r        <= 2'd0;
            cnt_r        <= 16'd0;
            gnt_r        <= 3'd0;
            start_conv_r <= 1'b0;
            chnnl_r      <= 3'd0;
            res_r        <= 12'd0;
            res_id_r     <= 2'd0;
            res_vld_r    <= 1'b0;
            tmo_err_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            gnt_r        <= 3'd0;
            start_conv_r <= 1'b0;
            res_vld_r    <= 1'b0;
            tmo_err_r    <= 1'b0;
            busy_r       <= (state_s != IDLE);
            if ((state_s != state_r) || (state_r == IDLE)) begin
                cnt_r <= 16'd0;
            end else begin
                cnt_r <= cnt_r + 16'd1;
            end
            case (state_r)
                IDLE: begin
                    if (pick_vld_s) begin
                        gnt_r        <= 3'b001 << pick_id_s;
                        start_conv_r <= 1'b1;
                        chnnl_r      <= pick_chnnl_s;
                        res_id_r     <= pick_id_s;
                        ptr_r        <= ptr_nxt_s;
                    end else begin
                        ptr_r <= ptr_r;
                    end
                end
                CONV: begin
                    if (cmplt_ok_s) begin
                        res_r     <= A2D_res;
                        res_vld_r <= 1'b1;
                    end else if (tmo_hit_s) begin
                        tmo_err_r <= 1'b1;
                    end else begin
                        res_r <= res_r;
                    end
                end
                default: begin
                    res_r <= res_r;
                end
            endcase
        end
    end

    assign gnt        = gnt_r;
    assign start_conv = start_conv_r;
    assign chnnl      = chnnl_r;
    assign res        = res_r;
    assign res_id     = res_id_r;
    assign res_vld    = res_vld_r;
    assign tmo_err    = tmo_err_r;
    assign busy       = busy_r;

endmodule
